// File: rtl/conn_admit_ctrl_pkg.sv
// Shared types and constants for the connection admission controller.
// Optional feature macro: CONN_REJECT_STATS_EN (reject statistics counter).
package conn_ctrl_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'b00,
    OCC_PARTIAL = 2'b01,
    OCC_FULL    = 2'b10
  } occ_e;

  localparam int unsigned REJ_CNT_W = 16;

  // Occupancy class of a connection count against the configured cap.
  function automatic occ_e occ_of(input int unsigned cnt, input int unsigned max_conn);
    if (cnt == 0)             return OCC_EMPTY;
    else if (cnt >= max_conn) return OCC_FULL;
    else                      return OCC_PARTIAL;
  endfunction

endpackage

// File: rtl/conn_admit_ctrl_if.sv
// Client-side request/grant bundle between client logic and the admission controller.
// Optional feature macro: CONN_REJECT_STATS_EN adds rej_clr / rej_cnt.
interface conn_admit_ctrl_if
  import conn_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned MAX_CONN  = 3,
  parameter int unsigned CNT_W     = $clog2(MAX_CONN + 1)
);

  logic [NUM_PORTS-1:0] conn_req;
  logic [NUM_PORTS-1:0] disc_req;
  logic [NUM_PORTS-1:0] conn_gnt;
  logic [NUM_PORTS-1:0] active;
  logic [CNT_W-1:0]     count;
  logic                 avail;
  occ_e                 occ_state;
`ifdef CONN_REJECT_STATS_EN
  logic                 rej_clr;
  logic [REJ_CNT_W-1:0] rej_cnt;

  modport master (output conn_req, disc_req, rej_clr,
                  input  conn_gnt, active, count, avail, occ_state, rej_cnt);
  modport slave  (input  conn_req, disc_req, rej_clr,
                  output conn_gnt, active, count, avail, occ_state, rej_cnt);
`else
  modport master (output conn_req, disc_req,
                  input  conn_gnt, active, count, avail, occ_state);
  modport slave  (input  conn_req, disc_req,
                  output conn_gnt, active, count, avail, occ_state);
`endif

endinterface

// File: rtl/conn_admit_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o,
  output logic                 any_o
);

  localparam int unsigned IDX_W = $clog2(N);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        found          = 1'b1;
        gnt_o[idx]     = 1'b1;
        gnt_idx_o      = IDX_W'(idx);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/conn_admit_ctrl.sv
// Admission controller: tracks active ports, caps them at MAX_CONN, grants one per cycle.
// Optional feature macro: CONN_REJECT_STATS_EN (saturating reject counter with clear).
module conn_admit_ctrl
  import conn_ctrl_pkg::*;
#(
  parameter int unsigned MAX_CONN  = 3,
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned CNT_W     = $clog2(MAX_CONN + 1)
) (
  input logic              clk,
  input logic              rst,
  conn_admit_ctrl_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0] active_q, active_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 avail_q, avail_d;
  occ_e                 occ_q, occ_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic [NUM_PORTS-1:0] disc_eff;
  logic [NUM_PORTS-1:0] cand;
  logic [NUM_PORTS-1:0] arb_gnt;
  logic [PTR_W-1:0]     arb_idx;
  logic                 arb_any;
  logic                 room;
  logic                 take;
  int unsigned          n_disc;
  int unsigned          remain;
  int unsigned          cnt_next;

  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .req_i     (cand),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .any_o     (arb_any)
  );

  // A slot released by a disconnect this cycle can be handed out in the same cycle.
  always_comb begin
    disc_eff = bus.disc_req & active_q;
    cand     = bus.conn_req & ~active_q & ~bus.disc_req;
    n_disc   = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      n_disc = n_disc + 32'(disc_eff[i]);
    end
    remain   = 32'(count_q) - n_disc;
    room     = remain < MAX_CONN;
    take     = room && arb_any;
    gnt_d    = take ? arb_gnt : '0;
    active_d = (active_q & ~disc_eff) | gnt_d;
    cnt_next = remain + 32'(take);
    count_d  = CNT_W'(cnt_next);
    avail_d  = cnt_next < MAX_CONN;
    occ_d    = occ_of(cnt_next, MAX_CONN);
    rr_ptr_d = take ? PTR_W'((32'(arb_idx) + 1) % NUM_PORTS) : rr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= '0;
      gnt_q    <= '0;
      count_q  <= '0;
      avail_q  <= 1'b1;
      occ_q    <= OCC_EMPTY;
      rr_ptr_q <= '0;
    end else begin
      active_q <= active_d;
      gnt_q    <= gnt_d;
      count_q  <= count_d;
      avail_q  <= avail_d;
      occ_q    <= occ_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef CONN_REJECT_STATS_EN
  logic [REJ_CNT_W-1:0] rej_cnt_q, rej_cnt_d;

  // Count cycles where someone wanted in but the cap blocked them; clear wins.
  always_comb begin
    rej_cnt_d = rej_cnt_q;
    if (bus.rej_clr) begin
      rej_cnt_d = '0;
    end else if ((cand != '0) && !room && (rej_cnt_q != {REJ_CNT_W{1'b1}})) begin
      rej_cnt_d = rej_cnt_q + REJ_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rej_cnt_q <= '0;
    else     rej_cnt_q <= rej_cnt_d;
  end

  assign bus.rej_cnt = rej_cnt_q;
`endif

  assign bus.conn_gnt  = gnt_q;
  assign bus.active    = active_q;
  assign bus.count     = count_q;
  assign bus.avail     = avail_q;
  assign bus.occ_state = occ_q;

endmodule

// File: tb/tb_conn_admit_ctrl.sv
// Self-checking bench for conn_admit_ctrl (MAX_CONN=3, NUM_PORTS=4) using a vector table
// and an expectation queue; covers CONN_REJECT_STATS_EN when that macro is defined.
module tb_conn_admit_ctrl;

  logic clk;
  logic rst;

  conn_admit_ctrl_if #(.NUM_PORTS(4), .MAX_CONN(3)) bus ();

  conn_admit_ctrl #(.MAX_CONN(3), .NUM_PORTS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] disc;
    logic       clr;
    logic [3:0] gnt;
    logic [3:0] act;
    int         cnt;
    logic       avail;
    logic [1:0] occ;
    int         rej;
  } vec_t;

  localparam logic [1:0] E = 2'b00;
  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] F = 2'b10;

  vec_t tbl[30];
  vec_t expq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic r, logic [3:0] rq, logic [3:0] dc, logic cl,
                              logic [3:0] g, logic [3:0] a, int c, logic av,
                              logic [1:0] oc, int rj);
    vec_t v;
    v.rst = r; v.req = rq; v.disc = dc; v.clr = cl;
    v.gnt = g; v.act = a; v.cnt = c; v.avail = av; v.occ = oc; v.rej = rj;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_pending(input string tag);
    vec_t e;
    if (expq.size() == 0) return;
    e = expq.pop_front();
    chk({tag, " conn_gnt"},  int'(bus.conn_gnt),  int'(e.gnt));
    chk({tag, " active"},    int'(bus.active),    int'(e.act));
    chk({tag, " count"},     int'(bus.count),     e.cnt);
    chk({tag, " avail"},     int'(bus.avail),     int'(e.avail));
    chk({tag, " occ_state"}, int'(bus.occ_state), int'(e.occ));
`ifdef CONN_REJECT_STATS_EN
    chk({tag, " rej_cnt"},   int'(bus.rej_cnt),   e.rej);
`endif
  endtask

  // Check the previous cycle's result, then drive this vector and queue its expectation.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    compare_pending(tag);
    rst          = v.rst;
    bus.conn_req = v.req;
    bus.disc_req = v.disc;
`ifdef CONN_REJECT_STATS_EN
    bus.rej_clr  = v.clr;
`endif
    expq.push_back(v);
  endtask

  initial begin
    rst          = 1'b1;
    bus.conn_req = '0;
    bus.disc_req = '0;
`ifdef CONN_REJECT_STATS_EN
    bus.rej_clr  = 1'b0;
`endif

    // rst, req, disc, clr | gnt, active, count, avail, occ, rej
    tbl[0]  = mk(1, 4'b1111, 4'b1010, 0, 4'b0000, 4'b0000, 0, 1, E, 0);
    tbl[1]  = mk(0, 4'b1111, 4'b0000, 0, 4'b0001, 4'b0001, 1, 1, P, 0);
    tbl[2]  = mk(0, 4'b1111, 4'b0000, 0, 4'b0010, 4'b0011, 2, 1, P, 0);
    tbl[3]  = mk(0, 4'b1111, 4'b0000, 0, 4'b0100, 4'b0111, 3, 0, F, 0);
    tbl[4]  = mk(0, 4'b1111, 4'b0000, 0, 4'b0000, 4'b0111, 3, 0, F, 1);
    tbl[5]  = mk(0, 4'b1111, 4'b0000, 0, 4'b0000, 4'b0111, 3, 0, F, 2);
    tbl[6]  = mk(0, 4'b1000, 4'b0010, 0, 4'b1000, 4'b1101, 3, 0, F, 2);
    tbl[7]  = mk(0, 4'b0000, 4'b1101, 0, 4'b0000, 4'b0000, 0, 1, E, 2);
    tbl[8]  = mk(0, 4'b0000, 4'b0001, 0, 4'b0000, 4'b0000, 0, 1, E, 2);
    tbl[9]  = mk(0, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 1, 1, P, 2);
    tbl[10] = mk(0, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0001, 1, 1, P, 2);
    tbl[11] = mk(0, 4'b0010, 4'b0000, 0, 4'b0010, 4'b0011, 2, 1, P, 2);
    tbl[12] = mk(0, 4'b0000, 4'b0011, 0, 4'b0000, 4'b0000, 0, 1, E, 2);
    tbl[13] = mk(0, 4'b0011, 4'b0000, 0, 4'b0001, 4'b0001, 1, 1, P, 2);
    tbl[14] = mk(0, 4'b0011, 4'b0000, 0, 4'b0010, 4'b0011, 2, 1, P, 2);
    tbl[15] = mk(0, 4'b0000, 4'b0011, 0, 4'b0000, 4'b0000, 0, 1, E, 2);
    tbl[16] = mk(0, 4'b1111, 4'b0000, 0, 4'b0100, 4'b0100, 1, 1, P, 2);
    tbl[17] = mk(0, 4'b0101, 4'b0100, 0, 4'b0001, 4'b0001, 1, 1, P, 2);
    tbl[18] = mk(0, 4'b1110, 4'b0000, 0, 4'b0010, 4'b0011, 2, 1, P, 2);
    tbl[19] = mk(0, 4'b1100, 4'b0000, 0, 4'b0100, 4'b0111, 3, 0, F, 2);
    tbl[20] = mk(0, 4'b0000, 4'b0111, 0, 4'b0000, 4'b0000, 0, 1, E, 2);
    tbl[21] = mk(0, 4'b0011, 4'b0000, 0, 4'b0001, 4'b0001, 1, 1, P, 2);
    tbl[22] = mk(0, 4'b0011, 4'b0000, 0, 4'b0010, 4'b0011, 2, 1, P, 2);
    tbl[23] = mk(1, 4'b1100, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1, E, 0);
    tbl[24] = mk(0, 4'b1100, 4'b0000, 0, 4'b0100, 4'b0100, 1, 1, P, 0);
    tbl[25] = mk(0, 4'b1011, 4'b0000, 0, 4'b1000, 4'b1100, 2, 1, P, 0);
    tbl[26] = mk(0, 4'b0011, 4'b0000, 0, 4'b0001, 4'b1101, 3, 0, F, 0);
    tbl[27] = mk(0, 4'b0010, 4'b0000, 0, 4'b0000, 4'b1101, 3, 0, F, 1);
    tbl[28] = mk(0, 4'b0010, 4'b0000, 1, 4'b0000, 4'b1101, 3, 0, F, 0);
    tbl[29] = mk(0, 4'b0010, 4'b0000, 0, 4'b0000, 4'b1101, 3, 0, F, 1);

    // Reset held with random traffic must leave everything at its reset value.
    for (int i = 0; i < 5; i++) begin
      apply(mk(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0,
               4'b0000, 4'b0000, 0, 1, E, 0), "reset");
    end

    for (int i = 0; i < 30; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Multi-cycle sequence: same-port disconnect and re-request must not be granted.
    apply(mk(0, 4'b0000, 4'b1101, 0, 4'b0000, 4'b0000, 0, 1, E, 1), "seq_drop");
    apply(mk(0, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 1, 1, P, 1), "seq_get");
    apply(mk(0, 4'b0001, 4'b0001, 0, 4'b0000, 4'b0000, 0, 1, E, 1), "seq_disc_req");
    apply(mk(0, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 1, 1, P, 1), "seq_regrant");
    apply(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0001, 1, 1, P, 1), "seq_idle");

    @(negedge clk);
    compare_pending("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
